// File: rtl/hazard_dest_pipe.sv
// rtl/hazard_dest_pipe.sv - destination-register pipe EX/MEM/WB with stall bubbles and stall-run checking
// Optional feature macro: HAZARD_STALL_CNT_EN (adds the 16-bit stall_count output)
module hazard_dest_pipe #(
   parameter int MAX_STALL_RUN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RegWrite_ID,
   input  logic [2:0] Write_register_ID,
   input  logic       stall,
   input  logic       flush_ID,
   output logic       RegWrite_EX,
   output logic [2:0] Write_register_EX,
   output logic       RegWrite_MEM,
   output logic [2:0] Write_register_MEM,
   output logic       RegWrite_WB,
   output logic [2:0] Write_register_WB,
   output logic       bubble_EX,
   output logic [7:0] pending,
   output logic       stall_err
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   localparam logic [1:0] RUN_LIMIT = 2'(MAX_STALL_RUN);

   logic [1:0] run_cnt;
   logic       insert_bubble;

   // A stall or a squash (or both at once) turns the EX load into a single bubble.
   assign insert_bubble = stall | flush_ID;

   // EX load from ID, then MEM and WB advance unconditionally behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWrite_EX        <= 1'b0;
         Write_register_EX  <= 3'b000;
         bubble_EX          <= 1'b1;
         RegWrite_MEM       <= 1'b0;
         Write_register_MEM <= 3'b000;
         RegWrite_WB        <= 1'b0;
         Write_register_WB  <= 3'b000;
      end else begin
         if (insert_bubble) begin
            RegWrite_EX       <= 1'b0;
            Write_register_EX <= 3'b000;
            bubble_EX         <= 1'b1;
         end else begin
            RegWrite_EX       <= RegWrite_ID;
            Write_register_EX <= Write_register_ID;
            bubble_EX         <= 1'b0;
         end
         RegWrite_MEM       <= RegWrite_EX;
         Write_register_MEM <= Write_register_EX;
         RegWrite_WB        <= RegWrite_MEM;
         Write_register_WB  <= Write_register_MEM;
      end
   end

   // Consecutive-stall run length, saturating; a stall beyond the legal run latches stall_err.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_cnt   <= 2'b00;
         stall_err <= 1'b0;
      end else begin
         if (stall) begin
            if (run_cnt != 2'b11) begin
               run_cnt <= run_cnt + 2'b01;
            end
            if (run_cnt == RUN_LIMIT) begin
               stall_err <= 1'b1;
            end
         end else begin
            run_cnt <= 2'b00;
         end
      end
   end

   // Register-indexed map of outstanding writes; the field only counts when its RegWrite is set.
   always_comb begin
      pending = 8'h00;
      if (RegWrite_EX) begin
         pending[Write_register_EX] = 1'b1;
      end
      if (RegWrite_MEM) begin
         pending[Write_register_MEM] = 1'b1;
      end
      if (RegWrite_WB) begin
         pending[Write_register_WB] = 1'b1;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   // Lifetime stall-cycle count, saturating at all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= 16'h0000;
      end else if (stall && (stall_count != 16'hFFFF)) begin
         stall_count <= stall_count + 16'h0001;
      end
   end
`endif

endmodule
